// File: rtl/clock_mode_ctrl.sv
// Front-panel mode controller for the digital clock.
// Conditions the raw MODE/INC buttons (2-flop synchronizer + debounce),
// sequences RUN / SET_HR / SET_MIN, and issues one-cycle increment and
// clear commands to the time counters.
// Also drives the field blink, INC auto-repeat and the set-mode idle timeout.
// Every output comes straight from a flop.
module clock_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter int unsigned REPEAT_DELAY    = 32'd25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 32'd10_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 32'd500_000_000,
  parameter int unsigned BLINK_HALF      = 32'd12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] state,
  output logic       hr_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic       blink
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_e;

  // Button bit positions inside the conditioning vectors.
  localparam int IDX_MODE = 0;
  localparam int IDX_INC  = 1;

  // Counter widths: each counter can hold its terminal value without wrapping.
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W = (DEBOUNCE_CYCLES > 32'd0) ? $clog2(DEBOUNCE_CYCLES + 32'd1) : 1;
  localparam int RP_W = (REP_MAX > 32'd0) ? $clog2(REP_MAX + 32'd1) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BL_W = (BLINK_HALF > 32'd1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1'b1);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_PERIOD = RP_W'(REPEAT_PERIOD);
  localparam logic [RP_W-1:0] RP_ONE    = RP_W'(1'b1);
  // Idle counter runs 0..TIMEOUT_CYCLES-1 while in a set mode, so the
  // set state lasts exactly TIMEOUT_CYCLES cycles when nothing happens.
  localparam logic [TO_W-1:0] TO_TERM   = TO_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1'b1);
  localparam logic [BL_W-1:0] BL_TERM   = BL_W'(BLINK_HALF - 32'd1);
  localparam logic [BL_W-1:0] BL_ONE    = BL_W'(1'b1);

  // ---------------- input conditioning ----------------
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            deb_prev_q, deb_prev_d;
  logic [1:0][DB_W-1:0]  dbcnt_q, dbcnt_d;

  logic mode_press_s;
  logic inc_press_s;

  // ---------------- control state ----------------
  logic [1:0]      state_q, state_d;
  logic            hr_inc_q, hr_inc_d;
  logic            min_inc_q, min_inc_d;
  logic            sec_clr_q, sec_clr_d;
  logic            blink_q, blink_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            rep_act_q, rep_act_d;
  logic            rep_first_q, rep_first_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;

  logic            rep_fire_s;
  logic            inc_pulse_s;
  logic [RP_W-1:0] rep_lim_s;

  // Synchronize both buttons and debounce: count while the synchronized
  // level disagrees with the debounced level, adopt it at the terminal count.
  always_comb begin
    sync1_d    = {btn_inc, btn_mode};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    dbcnt_d    = dbcnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        dbcnt_d[b] = '0;
      end else if (dbcnt_q[b] == DB_TERM) begin
        dbcnt_d[b] = '0;
        deb_d[b]   = sync2_q[b];
      end else begin
        dbcnt_d[b] = dbcnt_q[b] + DB_ONE;
      end
    end
  end

  // Conditioning registers: synchronizer stages, debounced levels, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      dbcnt_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dbcnt_q    <= dbcnt_d;
    end
  end

  // Press events are rising edges of the debounced levels; releases are ignored.
  always_comb begin
    mode_press_s = deb_q[IDX_MODE] & ~deb_prev_q[IDX_MODE];
    inc_press_s  = deb_q[IDX_INC]  & ~deb_prev_q[IDX_INC];
    rep_lim_s    = rep_first_q ? RP_PERIOD : RP_DELAY;
    rep_fire_s   = rep_act_q & deb_q[IDX_INC] & (rep_cnt_q == rep_lim_s);
  end

  // Mode FSM next state plus increment/clear pulses, auto-repeat, idle timeout and blink.
  always_comb begin
    state_d     = state_q;
    hr_inc_d    = 1'b0;
    min_inc_d   = 1'b0;
    sec_clr_d   = 1'b0;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    idle_d      = idle_q;
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    inc_pulse_s = 1'b0;

    case (state_q)
      ST_RUN: begin
        // INC is ignored here; all set-mode bookkeeping sits idle.
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        idle_d      = '0;
        rep_act_d   = 1'b0;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
        if (mode_press_s) begin
          state_d = ST_SET_HR;
          blink_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_SET_HR, ST_SET_MIN: begin
        if (mode_press_s) begin
          // MODE wins over a same-cycle INC press; a held INC must be
          // released and pressed again before it acts in the new mode.
          idle_d      = '0;
          blink_cnt_d = '0;
          rep_act_d   = 1'b0;
          rep_first_d = 1'b0;
          rep_cnt_d   = '0;
          if (state_q == ST_SET_HR) begin
            state_d = ST_SET_MIN;
            blink_d = 1'b1;
          end else begin
            state_d   = ST_RUN;
            blink_d   = 1'b0;
            sec_clr_d = 1'b1;
          end
        end else begin
          inc_pulse_s = inc_press_s | rep_fire_s;

          // Auto-repeat: first pulse REPEAT_DELAY after the press, then every REPEAT_PERIOD.
          if (inc_press_s) begin
            rep_act_d   = 1'b1;
            rep_first_d = 1'b0;
            rep_cnt_d   = RP_ONE;
          end else if (!rep_act_q || !deb_q[IDX_INC]) begin
            rep_act_d   = 1'b0;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
          end else if (rep_fire_s) begin
            rep_first_d = 1'b1;
            rep_cnt_d   = RP_ONE;
          end else begin
            rep_cnt_d   = rep_cnt_q + RP_ONE;
          end

          // Blink half-period counter.
          if (blink_cnt_q == BL_TERM) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BL_ONE;
          end

          // Any increment reloads the idle counter; otherwise time out to RUN.
          if (inc_pulse_s) begin
            idle_d    = '0;
            hr_inc_d  = (state_q == ST_SET_HR);
            min_inc_d = (state_q == ST_SET_MIN);
          end else if (idle_q == TO_TERM) begin
            state_d     = ST_RUN;
            sec_clr_d   = 1'b1;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
            idle_d      = '0;
            rep_act_d   = 1'b0;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
          end else begin
            idle_d = idle_q + TO_ONE;
          end
        end
      end

      default: begin
        // Unused encoding: silently recover to RUN with no pulses.
        state_d     = ST_RUN;
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        idle_d      = '0;
        rep_act_d   = 1'b0;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
      end
    endcase
  end

  // Control registers; reset abandons any set mode without issuing a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      hr_inc_q    <= 1'b0;
      min_inc_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      idle_q      <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hr_inc_q    <= hr_inc_d;
      min_inc_q   <= min_inc_d;
      sec_clr_q   <= sec_clr_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      idle_q      <= idle_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  assign state   = state_q;
  assign hr_inc  = hr_inc_q;
  assign min_inc = min_inc_q;
  assign sec_clr = sec_clr_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed testbench for clock_mode_ctrl with small parameters.
// Iteration i of every scenario loop drives the buttons at a falling edge
// and samples the outputs at the next falling edge, i.e. after rising edge i.
module tb_clock_mode_ctrl;

  localparam int unsigned DEB = 32'd4;
  localparam int unsigned RD  = 32'd20;
  localparam int unsigned RP  = 32'd8;
  localparam int unsigned TO  = 32'd100;
  localparam int unsigned BH  = 32'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] state;
  logic       hr_inc;
  logic       min_inc;
  logic       sec_clr;
  logic       blink;

  int n_tests = 0;
  int n_fail  = 0;

  clock_mode_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .TIMEOUT_CYCLES  (TO),
    .BLINK_HALF      (BH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .state    (state),
    .hr_inc   (hr_inc),
    .min_inc  (min_inc),
    .sec_clr  (sec_clr),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
  endtask

  // One clean MODE press: high 10 cycles, low 10 cycles.
  task automatic mode_press(output int chg_at, output int n_chg, output int n_sec,
                            output int sec_at, output int n_inc);
    logic [1:0] prev;
    prev   = state;
    chg_at = -1;
    n_chg  = 0;
    n_sec  = 0;
    sec_at = -1;
    n_inc  = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 10, 1'b0);
      if (state !== prev) begin
        n_chg++;
        if (chg_at < 0) chg_at = i;
      end
      prev = state;
      if (sec_clr) begin
        n_sec++;
        sec_at = i;
      end
      if (hr_inc || min_inc) n_inc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int chg_at, n_chg, n_sec, sec_at, n_inc;
    int nh, nm, bad_st, bad_bl, to_at, first_at;
    int at[8];
    int exp_st[3];
    int exp_rep[5];
    logic [1:0] st_exp;
    logic bl_exp;

    exp_st  = '{1, 2, 0};
    exp_rep = '{7, 27, 35, 43, 51};

    // ---------- reset ----------
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_hr_inc", 32'(hr_inc), 32'd0);
    check_eq("rst_min_inc", 32'(min_inc), 32'd0);
    check_eq("rst_sec_clr", 32'(sec_clr), 32'd0);
    check_eq("rst_blink", 32'(blink), 32'd0);
    rst = 1'b0;

    // ---------- mode cycle ----------
    for (int p = 0; p < 3; p++) begin
      mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
      check_eq("mode_latency", 32'(chg_at), 32'd7);
      check_eq("mode_state", 32'(state), 32'(exp_st[p]));
      check_eq("mode_nchanges", 32'(n_chg), 32'd1);
      check_eq("mode_sec_clr_cnt", 32'(n_sec), (p == 2) ? 32'd1 : 32'd0);
      check_eq("mode_inc_pulses", 32'(n_inc), 32'd0);
      if (p == 2) check_eq("mode_sec_clr_at", 32'(sec_at), 32'd7);
    end

    // ---------- INC in RUN ignored ----------
    nh = 0; bad_st = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, i < 30);
      if (hr_inc || min_inc || sec_clr) nh++;
      if (state !== 2'b00) bad_st++;
    end
    check_eq("run_inc_pulses", 32'(nh), 32'd0);
    check_eq("run_inc_state", 32'(bad_st), 32'd0);

    // ---------- INC auto-repeat in SET_MIN ----------
    mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
    mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
    check_eq("rep_enter_set_min", 32'(state), 32'd2);
    nh = 0; nm = 0;
    for (int k = 0; k < 8; k++) at[k] = -1;
    for (int i = 0; i < 70; i++) begin
      tick(1'b0, i < 50);
      if (min_inc) begin
        if (nm < 8) at[nm] = i;
        nm++;
      end
      if (hr_inc) nh++;
    end
    check_eq("rep_min_count", 32'(nm), 32'd5);
    for (int k = 0; k < 5; k++) check_eq("rep_min_at", 32'(at[k]), 32'(exp_rep[k]));
    check_eq("rep_hr_count", 32'(nh), 32'd0);

    mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
    check_eq("back_to_run_state", 32'(state), 32'd0);
    check_eq("back_to_run_sec_clr", 32'(n_sec), 32'd1);

    // ---------- bounce ----------
    nh = 0; bad_st = 0;
    for (int i = 0; i < 50; i++) begin
      tick((i < 30) ? (((i / 3) % 2) == 0) : 1'b0, 1'b0);
      if (hr_inc || min_inc || sec_clr) nh++;
      if (state !== 2'b00) bad_st++;
    end
    check_eq("bounce_state", 32'(bad_st), 32'd0);
    check_eq("bounce_pulses", 32'(nh), 32'd0);

    // ---------- simultaneous MODE+INC in SET_HR, INC held across change ----------
    mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
    check_eq("sim_enter_set_hr", 32'(state), 32'd1);
    nh = 0; nm = 0; chg_at = -1;
    for (int i = 0; i < 50; i++) begin
      tick(i < 10, i < 40);
      if (state === 2'b10 && chg_at < 0) chg_at = i;
      if (hr_inc) nh++;
      if (min_inc) nm++;
    end
    check_eq("sim_state", 32'(state), 32'd2);
    check_eq("sim_change_at", 32'(chg_at), 32'd7);
    check_eq("sim_hr_inc", 32'(nh), 32'd0);
    check_eq("sim_held_min_inc", 32'(nm), 32'd0);
    nh = 0; nm = 0; first_at = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, i < 10);
      if (min_inc) begin
        nm++;
        if (first_at < 0) first_at = i;
      end
      if (hr_inc) nh++;
    end
    check_eq("repress_min_count", 32'(nm), 32'd1);
    check_eq("repress_min_at", 32'(first_at), 32'd7);
    check_eq("repress_hr_count", 32'(nh), 32'd0);

    // ---------- timeout and blink ----------
    mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
    check_eq("to_pre_state", 32'(state), 32'd0);
    bad_st = 0; bad_bl = 0; to_at = -1; n_sec = 0; sec_at = -1; nh = 0;
    for (int i = 0; i < 120; i++) begin
      tick(i < 10, 1'b0);
      st_exp = (i >= 7 && i < 107) ? 2'b01 : 2'b00;
      bl_exp = (i >= 7 && i < 107) ? (((i - 7) / 5) % 2 == 0) : 1'b0;
      if (state !== st_exp) bad_st++;
      if (blink !== bl_exp) bad_bl++;
      if (i > 7 && state === 2'b00 && to_at < 0) to_at = i;
      if (sec_clr) begin
        n_sec++;
        sec_at = i;
      end
      if (hr_inc || min_inc) nh++;
      if (i == 7) check_eq("blink_on_entry", 32'(blink), 32'd1);
      if (i == 12) check_eq("blink_first_off", 32'(blink), 32'd0);
      if (i == 107) check_eq("blink_after_timeout", 32'(blink), 32'd0);
    end
    check_eq("to_state_pattern", 32'(bad_st), 32'd0);
    check_eq("to_blink_pattern", 32'(bad_bl), 32'd0);
    check_eq("to_return_at", 32'(to_at), 32'd107);
    check_eq("to_sec_clr_cnt", 32'(n_sec), 32'd1);
    check_eq("to_sec_clr_at", 32'(sec_at), 32'd107);
    check_eq("to_inc_pulses", 32'(nh), 32'd0);

    // ---------- reset during auto-repeat ----------
    mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
    mode_press(chg_at, n_chg, n_sec, sec_at, n_inc);
    check_eq("rst_enter_set_min", 32'(state), 32'd2);
    nm = 0;
    for (int i = 0; i < 31; i++) begin
      tick(1'b0, 1'b1);
      if (min_inc) nm++;
    end
    check_eq("rst_pre_min_count", 32'(nm), 32'd2);
    rst = 1'b1;
    tick(1'b0, 1'b1);
    check_eq("rst_mid_state", 32'(state), 32'd0);
    check_eq("rst_mid_pulses", 32'({hr_inc, min_inc, sec_clr}), 32'd0);
    check_eq("rst_mid_blink", 32'(blink), 32'd0);
    rst = 1'b0;
    nh = 0; bad_st = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, i < 40);
      if (hr_inc || min_inc || sec_clr) nh++;
      if (state !== 2'b00) bad_st++;
    end
    check_eq("rst_post_pulses", 32'(nh), 32'd0);
    check_eq("rst_post_state", 32'(bad_st), 32'd0);

    // ---------- illegal state recovery ----------
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    @(negedge clk);
    check_eq("illegal_recover_state", 32'(state), 32'd0);
    check_eq("illegal_recover_pulses", 32'({hr_inc, min_inc, sec_clr}), 32'd0);
    check_eq("illegal_recover_blink", 32'(blink), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("illegal_settled_state", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
